// File: rtl/pipe_add_sub.sv
// ---------------------------------------------------------------------------
// pipe_add_sub
//   Pipelined two's-complement adder/subtractor with a valid/ready handshake
//   on both sides. The carry chain is split into STAGES chunks of
//   CHUNK = WIDTH/STAGES bits. Each stage resolves one chunk using the carry
//   registered by the previous stage. One operation per cycle is sustained,
//   and full backpressure is supported.
//
//   Parameters
//     WIDTH   operand/result width (>= 2)
//     STAGES  pipeline depth (1..WIDTH, WIDTH % STAGES == 0)
//
//   Optional build macro
//     ADD_SAT_EN  when defined, the sum saturates toward the sign of A on
//                 signed overflow. ovf and cout still report the raw
//                 (unsaturated) result. zero and neg follow the saturated sum.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready upstream handshake for a, b, sub, cin
//     a, b              operands
//     sub               0: a + b + cin     1: a - b - cin (cin = borrow-in)
//     cin               carry-in / borrow-in
//     out_valid/out_ready downstream handshake
//     sum               result
//     cout              carry out of the MSB (for sub, 1 = no borrow)
//     ovf               signed overflow
//     zero              sum == 0
//     neg               sum MSB
// ---------------------------------------------------------------------------
module pipe_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CHUNK = WIDTH / STAGES;

    // Pipeline registers; index k holds the contents of stage k.
    logic [STAGES-1:0] vld_p;
    logic [WIDTH-1:0]  a_p   [STAGES];
    logic [WIDTH-1:0]  bx_p  [STAGES];
    logic [WIDTH-1:0]  sum_p [STAGES];
    logic [STAGES-1:0] c_p;
    logic              ovf_p;
    logic              zero_p;
    logic              neg_p;

    // Per-stage inputs and combinational results.
    logic [WIDTH-1:0]  a_i   [STAGES];
    logic [WIDTH-1:0]  bx_i  [STAGES];
    logic [WIDTH-1:0]  s_i   [STAGES];
    logic [WIDTH-1:0]  sum_n [STAGES];
    logic [STAGES-1:0] c_i;
    logic [STAGES-1:0] c_n;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vld_in;

`ifdef ADD_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                                 input logic             ov,
                                                 input logic             a_msb);
        if (!ov)
            return raw;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // A stage advances when it is empty or the stage after it advances.
    // Walking from the output back keeps in_ready free of any in_valid path.
    always_comb begin : adv_chain
        logic nxt;
        adv = '0;
        nxt = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            nxt    = !vld_p[k] || nxt;
            adv[k] = nxt;
        end
    end

    always_comb begin
        vld_in    = vld_p << 1;
        vld_in[0] = in_valid;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] s_new;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + !cin; inverting b here means the later
            // stages only ever add.
            assign a_i[k]  = a;
            assign bx_i[k] = sub ? ~b : b;
            assign s_i[k]  = '0;
            assign c_i[k]  = sub ^ cin;
        end else begin : g_next
            assign a_i[k]  = a_p[k-1];
            assign bx_i[k] = bx_p[k-1];
            assign s_i[k]  = sum_p[k-1];
            assign c_i[k]  = c_p[k-1];
        end

        assign part = {1'b0, a_i[k][k*CHUNK +: CHUNK]}
                    + {1'b0, bx_i[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_i[k]};

        always_comb begin
            s_new                    = s_i[k];
            s_new[k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
        end

        assign sum_n[k] = s_new;
        assign c_n[k]   = part[CHUNK];
    end

    // Last-stage flags. The carry into the MSB is recovered as
    // a ^ b ^ sum at that bit, so no separate carry tap is needed.
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_sum;
    logic             ovf_n;

    assign raw_sum = sum_n[STAGES-1];
    assign ovf_n   = a_i[STAGES-1][WIDTH-1] ^ bx_i[STAGES-1][WIDTH-1]
                   ^ raw_sum[WIDTH-1] ^ c_n[STAGES-1];

`ifdef ADD_SAT_EN
    assign fin_sum = sat_sum(raw_sum, ovf_n, a_i[STAGES-1][WIDTH-1]);
`else
    assign fin_sum = raw_sum;
`endif

    // Stage valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (adv[k])
                    vld_p[k] <= vld_in[k];
        end
    end

    // Stage data. A stalled stage keeps its contents, which holds the outputs.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                a_p[k]   <= a_i[k];
                bx_p[k]  <= bx_i[k];
                sum_p[k] <= (k == STAGES - 1) ? fin_sum : sum_n[k];
                c_p[k]   <= c_n[k];
            end
        end
        if (adv[STAGES-1]) begin
            ovf_p  <= ovf_n;
            zero_p <= (fin_sum == '0);
            neg_p  <= fin_sum[WIDTH-1];
        end
    end

    // Outputs. Data registers are not reset, so the results are gated by
    // valid to read as zero whenever nothing is being presented.
    assign in_ready  = adv[0];
    assign out_valid = vld_p[STAGES-1];
    assign sum       = out_valid ? sum_p[STAGES-1] : '0;
    assign cout      = out_valid & c_p[STAGES-1];
    assign ovf       = out_valid & ovf_p;
    assign zero      = out_valid & zero_p;
    assign neg       = out_valid & neg_p;

endmodule

// File: tb/tb_pipe_add_sub.sv
module tb_pipe_add_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, neg;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [19:0] exp_q[$];
    int          acc_q[$];
    logic        acc_f, del_f;
    logic [19:0] last_res;
    int          last_lat;
    logic        prev_hold = 1'b0;
    logic [20:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {sum, cout, ovf, zero, neg}; overflow by the sign rule.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input logic ci);
        logic [15:0] yb;
        logic [16:0] full;
        logic [15:0] r;
        logic        o;
        yb   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {16'b0, (s ? !ci : ci)};
        r    = full[15:0];
        o    = (x[15] == yb[15]) && (r[15] != x[15]);
`ifdef ADD_SAT_EN
        if (o) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, full[16], o, (r == 16'h0000), r[15]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    // One clock: drive at negedge, settle, then account for the handshakes
    // that will take effect on the next rising edge.
    task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic icin, input logic ordy);
        logic [20:0] cur;
        logic [19:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        out_ready = ordy;
        #1;
        cyc++;
        cur = {out_valid, sum, cout, ovf, zero, neg};
        if (prev_hold) chk("hold_stable", 32'(cur), 32'(prev_out));
        prev_hold = out_valid && !ordy;
        prev_out  = cur;
        acc_f = iv && in_ready;
        del_f = out_valid && ordy;
        if (del_f) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", exp_q.size(), 1);
            end else begin
                e        = exp_q.pop_front();
                last_lat = cyc - acc_q.pop_front();
                last_res = cur[19:0];
                chk("result", 32'(cur[19:0]), 32'(e));
            end
        end
        if (acc_f) begin
            exp_q.push_back(model(ia, ib, isub, icin));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic run_single(input logic [15:0] ia, input logic [15:0] ib,
                              input logic isub, input logic icin);
        cycle(1'b1, ia, ib, isub, icin, 1'b1);
        chk("single_accept", 32'(acc_f), 1);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("single_drained", exp_q.size(), 0);
        chk("single_latency", last_lat, 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc10, gaps, delivered, idx, sent, nacc, ndel;
        logic have;
        logic [15:0] ra, rb;
        logic rs, rc;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_outputs", 32'({sum, cout, ovf, zero, neg}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t1_fields", 32'(last_res), 32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}));
        run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0);
`ifdef ADD_SAT_EN
        chk("t2_fields", 32'(last_res), 32'({16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}));
`else
        chk("t2_fields", 32'(last_res), 32'({16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}));
`endif
        run_single(16'h0005, 16'h0007, 1'b1, 1'b0);
        chk("t3a_fields", 32'(last_res), 32'({16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1}));
        run_single(16'h8000, 16'h0001, 1'b1, 1'b0);
`ifdef ADD_SAT_EN
        chk("t3b_fields", 32'(last_res), 32'({16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}));
`else
        chk("t3b_fields", 32'(last_res), 32'({16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}));
`endif
        run_single(16'h1234, 16'h1234, 1'b1, 1'b1);
        chk("borrow_in", 32'(last_res), 32'({16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1}));

        // Backpressure: 8 ops, out_ready low for the first 10 cycles
        acc10 = 0; gaps = 0; delivered = 0; idx = 0;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            cycle(idx < 8, 16'(idx * 16'h1234 + 1), 16'(idx * 7), idx[0], idx[1], c >= 10);
            if (c == 9) chk("bp_in_ready_low", 32'(in_ready), 0);
            if (acc_f) idx++;
            if (c < 10 && acc_f) acc10++;
            if (c >= 10) begin
                if (del_f) delivered++;
                else gaps++;
            end
        end
        chk("bp_accepts", acc10, 4);
        chk("bp_gaps", gaps, 0);
        chk("bp_delivered", delivered, 8);

        // Reset with 3 ops in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'(16'h0100 + i), 16'h0011, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_outputs", 32'({sum, cout, ovf, zero, neg}), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        acc_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_single(16'h0003, 16'h0004, 1'b0, 1'b0);
        chk("post_rst_fields", 32'(last_res), 32'({16'h0007, 1'b0, 1'b0, 1'b0, 1'b0}));
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Random stream
        sent = 0; have = 1'b0;
        ra = '0; rb = '0; rs = 1'b0; rc = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            if (!have) begin
                ra = rnd16(); rb = rnd16();
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            cycle($urandom_range(0, 9) < 7, ra, rb, rs, rc, $urandom_range(0, 9) < 7);
            if (acc_f) begin
                sent++;
                have = 1'b0;
            end
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rand_sent", sent, 10000);
        chk("rand_drained", exp_q.size(), 0);

        // Throughput with both sides held high
        nacc = 0; ndel = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            if (acc_f) nacc++;
            if (del_f) ndel++;
        end
        chk("tput_accepts", nacc, 20);
        chk("tput_delivers", ndel, 16);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++)
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("tput_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
